// File: rtl/turfio_register_responder_if.sv
// Bus bundle for the TURFIO register responder: inbound command stream, outbound
// response stream and the local Wishbone master port.
interface turfio_register_responder_if;
    logic [31:0] s_cmd_tdata;
    logic        s_cmd_tvalid;
    logic        s_cmd_tready;
    logic        s_cmd_tlast;
    logic [31:0] m_resp_tdata;
    logic        m_resp_tvalid;
    logic        m_resp_tready;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [24:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;

    // slave: the responder itself (consumes commands, drives responses and Wishbone)
    modport slave (
        input  s_cmd_tdata, s_cmd_tvalid, s_cmd_tlast, m_resp_tready,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        output s_cmd_tready, m_resp_tdata, m_resp_tvalid,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );

    // master: the environment (command source, response sink, Wishbone target)
    modport master (
        output s_cmd_tdata, s_cmd_tvalid, s_cmd_tlast, m_resp_tready,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
        input  s_cmd_tready, m_resp_tdata, m_resp_tvalid,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o
    );
endinterface

// File: rtl/turfio_register_responder.sv
// TURFIO end of the crate register bridge: decodes command words into single Wishbone
// accesses and returns one response word per read.
module turfio_register_responder #(
    parameter int unsigned WB_TIMEOUT = 1023
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    turfio_register_responder_if.slave         io_bus,
    output logic                               timeout_o,
    output logic                               framing_error_o
);
    localparam logic [15:0] TimeoutLast = 16'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StData, StWb, StResp, StDrain} state_e;

    state_e      r_state;
    logic        r_cmd_tready;
    logic        r_cyc;
    logic        r_we;
    logic [22:0] r_adr;
    logic [31:0] r_wdata;
    logic [31:0] r_resp_tdata;
    logic        r_resp_tvalid;
    logic [15:0] r_cnt;
    logic        r_timeout;
    logic        r_framing;

    logic w_beat;
    logic w_last;
    logic w_hdr_read;
    logic w_term;
    logic w_unused_hdr;

    assign w_beat       = io_bus.s_cmd_tvalid & r_cmd_tready;
    assign w_last       = io_bus.s_cmd_tlast;
    assign w_hdr_read   = io_bus.s_cmd_tdata[31];
    assign w_term       = io_bus.wb_ack_i | io_bus.wb_err_i | io_bus.wb_rty_i;
    assign w_unused_hdr = ^{io_bus.s_cmd_tdata[30:25], io_bus.s_cmd_tdata[1:0]};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= StIdle;
            r_cmd_tready  <= 1'b0;
            r_cyc         <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_wdata       <= '0;
            r_resp_tdata  <= '0;
            r_resp_tvalid <= 1'b0;
            r_cnt         <= '0;
            r_timeout     <= 1'b0;
            r_framing     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_framing <= 1'b0;
            case (r_state)
                StIdle: begin
                    // tready comes up one cycle after reset release
                    r_cmd_tready <= 1'b1;
                    if (w_beat) begin
                        r_adr <= io_bus.s_cmd_tdata[24:2];
                        r_we  <= ~w_hdr_read;
                        if (w_hdr_read && w_last) begin
                            r_state      <= StWb;
                            r_cyc        <= 1'b1;
                            r_cmd_tready <= 1'b0;
                            r_cnt        <= '0;
                        end else if (!w_hdr_read && !w_last) begin
                            r_state <= StData;
                        end else begin
                            r_framing <= 1'b1;
                            if (!w_last) r_state <= StDrain;
                        end
                    end
                end
                StData: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_wdata      <= io_bus.s_cmd_tdata;
                            r_state      <= StWb;
                            r_cyc        <= 1'b1;
                            r_cmd_tready <= 1'b0;
                            r_cnt        <= '0;
                        end else begin
                            r_framing <= 1'b1;
                            r_state   <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_beat && w_last) r_state <= StIdle;
                end
                StWb: begin
                    // A real termination on the limit cycle takes priority over the timeout
                    if (w_term || r_cnt == TimeoutLast) begin
                        r_cyc <= 1'b0;
                        if (!w_term) r_timeout <= 1'b1;
                        if (r_we) begin
                            r_state      <= StIdle;
                            r_cmd_tready <= 1'b1;
                        end else begin
                            r_resp_tdata  <= io_bus.wb_ack_i ? io_bus.wb_dat_i : 32'hFFFF_FFFF;
                            r_resp_tvalid <= 1'b1;
                            r_state       <= StResp;
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                StResp: begin
                    if (io_bus.m_resp_tready) begin
                        r_resp_tvalid <= 1'b0;
                        r_state       <= StIdle;
                        r_cmd_tready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= StIdle;
                    r_cyc        <= 1'b0;
                    r_cmd_tready <= 1'b1;
                end
            endcase
        end
    end

    assign io_bus.s_cmd_tready  = r_cmd_tready;
    assign io_bus.m_resp_tdata  = r_resp_tdata;
    assign io_bus.m_resp_tvalid = r_resp_tvalid;
    assign io_bus.wb_cyc_o      = r_cyc;
    assign io_bus.wb_stb_o      = r_cyc;
    assign io_bus.wb_we_o       = r_we;
    assign io_bus.wb_adr_o      = {r_adr, 2'b00};
    assign io_bus.wb_dat_o      = r_wdata;
    assign io_bus.wb_sel_o      = 4'hF;
    assign timeout_o            = r_timeout;
    assign framing_error_o      = r_framing;
endmodule

// File: tb/tb_turfio_register_responder.sv
// Self-checking bench for turfio_register_responder: directed scenarios plus a randomized
// command stream checked against a register-file model.
module tb_turfio_register_responder;
    logic clk = 1'b0;
    logic rst;
    logic timeout_o;
    logic framing_error_o;
    int   n_checks = 0;
    int   n_errors = 0;

    turfio_register_responder_if bus ();

    turfio_register_responder #(.WB_TIMEOUT(16)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .io_bus          (bus.slave),
        .timeout_o       (timeout_o),
        .framing_error_o (framing_error_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] data, input logic last);
        int n = 0;
        bus.s_cmd_tdata  = data;
        bus.s_cmd_tlast  = last;
        bus.s_cmd_tvalid = 1'b1;
        while (bus.s_cmd_tready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus.s_cmd_tready !== 1'b1) begin
            n_errors++;
            $display("FAIL cmd_accept: tready=%b after %0d cycles, required 1", bus.s_cmd_tready, n);
        end
        tick();
        bus.s_cmd_tvalid = 1'b0;
        bus.s_cmd_tlast  = 1'b0;
    endtask

    // kind: 0 ack, 1 err, 2 rty, 3 never terminate
    task automatic wb_serve(input int kind, input int delay, input logic [31:0] rdata,
                            output logic [24:0] adr, output logic we, output logic [31:0] dat,
                            output logic [3:0] sel, output int held, output logic tmo);
        int n = 0;
        held = 0; adr = '0; we = 1'b0; dat = '0; sel = '0; tmo = 1'b0;
        while (bus.wb_cyc_o !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b1) begin
            n_errors++;
            $display("FAIL wb_start: cyc=%b stb=%b, required 1/1", bus.wb_cyc_o, bus.wb_stb_o);
            return;
        end
        adr = bus.wb_adr_o; we = bus.wb_we_o; dat = bus.wb_dat_o; sel = bus.wb_sel_o;
        if (kind == 3) begin
            while (bus.wb_cyc_o === 1'b1 && held < 200) begin
                held++;
                tick();
            end
        end else begin
            repeat (delay) begin
                if (bus.wb_cyc_o === 1'b1) held++;
                tick();
            end
            held++;
            bus.wb_dat_i = rdata;
            bus.wb_ack_i = (kind == 0);
            bus.wb_err_i = (kind == 1);
            bus.wb_rty_i = (kind == 2);
            tick();
            bus.wb_ack_i = 1'b0;
            bus.wb_err_i = 1'b0;
            bus.wb_rty_i = 1'b0;
            bus.wb_dat_i = $urandom;
        end
        tmo = timeout_o;
    endtask

    task automatic get_resp(output logic [31:0] data);
        int n = 0;
        data = '0;
        while (bus.m_resp_tvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus.m_resp_tvalid !== 1'b1) begin
            n_errors++;
            $display("FAIL resp_valid: tvalid=%b, required 1", bus.m_resp_tvalid);
            return;
        end
        data = bus.m_resp_tdata;
        bus.m_resp_tready = 1'b1;
        tick();
        bus.m_resp_tready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.m_resp_tvalid, bus.s_cmd_tready,
             timeout_o, framing_error_o} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: cyc/stb/we/rv/tr/to/fe=%b, required 0000000",
                     {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.m_resp_tvalid,
                      bus.s_cmd_tready, timeout_o, framing_error_o});
        end
        n_checks++;
        if (bus.wb_adr_o !== 25'h0 || bus.wb_dat_o !== 32'h0 || bus.m_resp_tdata !== 32'h0 ||
            bus.wb_sel_o !== 4'hF) begin
            n_errors++;
            $display("FAIL reset_data: adr=%h dat=%h resp=%h sel=%h, required 0 0 0 f",
                     bus.wb_adr_o, bus.wb_dat_o, bus.m_resp_tdata, bus.wb_sel_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic spurious = 1'b0;
        send_beat(32'h0000_1234, 1'b0);
        send_beat(32'hDEAD_BEEF, 1'b1);
        n_checks++;
        if (bus.wb_cyc_o !== 1'b1) begin
            n_errors++;
            $display("FAIL write_latency: cyc=%b right after data beat, required 1", bus.wb_cyc_o);
        end
        wb_serve(0, 3, 32'h0, adr, we, dat, sel, held, tmo);
        n_checks++;
        if ({adr, we, dat, sel} !== {25'h1234, 1'b1, 32'hDEAD_BEEF, 4'hF}) begin
            n_errors++;
            $display("FAIL write_access: adr=%h we=%b dat=%h sel=%h, required 1234 1 deadbeef f",
                     adr, we, dat, sel);
        end
        n_checks++;
        if (held !== 4 || bus.wb_cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL write_cycle: held=%0d cyc_after=%b, required 4 0", held, bus.wb_cyc_o);
        end
        repeat (8) begin
            if (bus.m_resp_tvalid !== 1'b0) spurious = 1'b1;
            tick();
        end
        n_checks++;
        if (spurious !== 1'b0) begin
            n_errors++;
            $display("FAIL write_no_resp: response seen=%b, required 0", spurious);
        end
    endtask

    task automatic test_read();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp;
        send_beat(32'h8000_0010, 1'b1);
        n_checks++;
        if (bus.wb_cyc_o !== 1'b1 || bus.wb_we_o !== 1'b0) begin
            n_errors++;
            $display("FAIL read_latency: cyc=%b we=%b after header, required 1 0",
                     bus.wb_cyc_o, bus.wb_we_o);
        end
        wb_serve(0, 0, 32'hCAFE_F00D, adr, we, dat, sel, held, tmo);
        n_checks++;
        if (adr !== 25'h10 || we !== 1'b0) begin
            n_errors++;
            $display("FAIL read_access: adr=%h we=%b, required 10 0", adr, we);
        end
        n_checks++;
        if (bus.m_resp_tvalid !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL read_turnaround: tvalid=%b cyc=%b at N+2, required 1 0",
                     bus.m_resp_tvalid, bus.wb_cyc_o);
        end
        get_resp(resp);
        n_checks++;
        if (resp !== 32'hCAFE_F00D || bus.m_resp_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL read_resp: data=%h tvalid_after=%b, required cafef00d 0",
                     resp, bus.m_resp_tvalid);
        end
    endtask

    task automatic test_timeout();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp;
        send_beat(32'h8000_0040, 1'b1);
        wb_serve(3, 0, 32'h0, adr, we, dat, sel, held, tmo);
        n_checks++;
        if (held !== 16 || tmo !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_hold: held=%0d pulse=%b, required 16 1", held, tmo);
        end
        tick();
        n_checks++;
        if (timeout_o !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_pulse_width: timeout_o=%b second cycle, required 0", timeout_o);
        end
        get_resp(resp);
        n_checks++;
        if (resp !== 32'hFFFF_FFFF) begin
            n_errors++;
            $display("FAIL timeout_resp: data=%h, required ffffffff", resp);
        end
        // ack landing on the final allowed cycle must win over the timeout
        send_beat(32'h8000_0044, 1'b1);
        wb_serve(0, 15, 32'h0BAD_CAFE, adr, we, dat, sel, held, tmo);
        get_resp(resp);
        n_checks++;
        if (held !== 16 || tmo !== 1'b0 || resp !== 32'h0BAD_CAFE) begin
            n_errors++;
            $display("FAIL ack_at_limit: held=%0d pulse=%b data=%h, required 16 0 0badcafe",
                     held, tmo, resp);
        end
        for (int k = 1; k <= 2; k++) begin
            send_beat(32'h8000_0048, 1'b1);
            wb_serve(k, 2, 32'h1234_5678, adr, we, dat, sel, held, tmo);
            get_resp(resp);
            n_checks++;
            if (tmo !== 1'b0 || resp !== 32'hFFFF_FFFF) begin
                n_errors++;
                $display("FAIL err_rty_resp kind=%0d: pulse=%b data=%h, required 0 ffffffff",
                         k, tmo, resp);
            end
        end
    endtask

    task automatic test_framing();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp;
        logic cyc_seen = 1'b0;
        send_beat(32'h0000_0100, 1'b1);
        n_checks++;
        if (framing_error_o !== 1'b1 || bus.wb_cyc_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_write_last: fe=%b cyc=%b, required 1 0",
                     framing_error_o, bus.wb_cyc_o);
        end
        tick();
        n_checks++;
        if (framing_error_o !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_pulse_width: fe=%b, required 0", framing_error_o);
        end
        send_beat(32'h8000_0020, 1'b0);
        n_checks++;
        if (framing_error_o !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_read_nolast: fe=%b, required 1", framing_error_o);
        end
        send_beat(32'h8000_0024, 1'b0);
        cyc_seen |= bus.wb_cyc_o;
        send_beat(32'h0000_0028, 1'b1);
        cyc_seen |= bus.wb_cyc_o;
        // bad data phase: second write beat without tlast
        send_beat(32'h0000_0030, 1'b0);
        send_beat(32'h1111_1111, 1'b0);
        n_checks++;
        if (framing_error_o !== 1'b1) begin
            n_errors++;
            $display("FAIL frame_data_nolast: fe=%b, required 1", framing_error_o);
        end
        cyc_seen |= bus.wb_cyc_o;
        send_beat(32'h2222_2222, 1'b1);
        cyc_seen |= bus.wb_cyc_o;
        tick();
        cyc_seen |= bus.wb_cyc_o;
        n_checks++;
        if (cyc_seen !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_no_wb: cyc seen=%b while draining, required 0", cyc_seen);
        end
        send_beat(32'h8000_0030, 1'b1);
        wb_serve(0, 1, 32'h5555_AAAA, adr, we, dat, sel, held, tmo);
        get_resp(resp);
        n_checks++;
        if (adr !== 25'h30 || resp !== 32'h5555_AAAA) begin
            n_errors++;
            $display("FAIL frame_recover: adr=%h data=%h, required 30 5555aaaa", adr, resp);
        end
    endtask

    task automatic test_backpressure();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp;
        logic bad = 1'b0;
        send_beat(32'h8000_0060, 1'b1);
        wb_serve(0, 0, 32'hA5A5_5A5A, adr, we, dat, sel, held, tmo);
        repeat (10) begin
            if (bus.m_resp_tvalid !== 1'b1 || bus.m_resp_tdata !== 32'hA5A5_5A5A ||
                bus.s_cmd_tready !== 1'b0) bad = 1'b1;
            tick();
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_errors++;
            $display("FAIL backpressure_hold: unstable=%b, required 0", bad);
        end
        get_resp(resp);
        n_checks++;
        if (resp !== 32'hA5A5_5A5A) begin
            n_errors++;
            $display("FAIL backpressure_data: data=%h, required a5a55a5a", resp);
        end
        send_beat(32'h8000_0064, 1'b1);
        wb_serve(0, 0, 32'h0000_0064, adr, we, dat, sel, held, tmo);
        get_resp(resp);
        n_checks++;
        if (adr !== 25'h64 || resp !== 32'h0000_0064) begin
            n_errors++;
            $display("FAIL backpressure_next: adr=%h data=%h, required 64 64", adr, resp);
        end
    endtask

    task automatic test_reset_mid_wb();
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp;
        logic spurious = 1'b0;
        send_beat(32'h8000_0070, 1'b1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || bus.m_resp_tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async: cyc=%b stb=%b tvalid=%b, required 0 0 0",
                     bus.wb_cyc_o, bus.wb_stb_o, bus.m_resp_tvalid);
        end
        tick();
        rst = 1'b0;
        repeat (5) begin
            if (bus.m_resp_tvalid !== 1'b0 || bus.wb_cyc_o !== 1'b0) spurious = 1'b1;
            tick();
        end
        n_checks++;
        if (spurious !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_no_resp: activity=%b after reset, required 0", spurious);
        end
        send_beat(32'h8000_0074, 1'b1);
        wb_serve(0, 2, 32'h7777_0074, adr, we, dat, sel, held, tmo);
        get_resp(resp);
        n_checks++;
        if (adr !== 25'h74 || resp !== 32'h7777_0074) begin
            n_errors++;
            $display("FAIL reset_recover: adr=%h data=%h, required 74 77770074", adr, resp);
        end
    endtask

    task automatic test_random();
        logic [31:0] model_mem [8];
        logic [24:0] adr; logic we; logic [31:0] dat; logic [3:0] sel; int held; logic tmo;
        logic [31:0] resp, hdr, wdata, exp_resp;
        logic [22:0] word_adr;
        int idx, sel_kind, kind, delay;
        logic is_read;
        for (int i = 0; i < 8; i++) model_mem[i] = $urandom;
        for (int t = 0; t < 30; t++) begin
            idx      = $urandom_range(0, 7);
            is_read  = ($urandom_range(0, 1) == 1);
            sel_kind = $urandom_range(0, 9);
            kind     = (sel_kind <= 5 || sel_kind == 9) ? 0 : sel_kind - 5;
            delay    = $urandom_range(0, 4);
            wdata    = $urandom;
            word_adr = 23'h12340 + 23'(idx);
            hdr      = {is_read, 6'($urandom), word_adr, 2'($urandom)};
            send_beat(hdr, is_read);
            if (!is_read) send_beat(wdata, 1'b1);
            wb_serve(kind, delay, model_mem[idx], adr, we, dat, sel, held, tmo);
            n_checks++;
            if (adr !== {word_adr, 2'b00} || we !== !is_read || tmo !== (kind == 3) ||
                (!is_read && dat !== wdata)) begin
                n_errors++;
                $display("FAIL rand_access t=%0d: adr=%h we=%b dat=%h to=%b, required %h %b %h %b",
                         t, adr, we, dat, tmo, {word_adr, 2'b00}, !is_read, wdata, kind == 3);
            end
            if (is_read) begin
                exp_resp = (kind == 0) ? model_mem[idx] : 32'hFFFF_FFFF;
                get_resp(resp);
                n_checks++;
                if (resp !== exp_resp) begin
                    n_errors++;
                    $display("FAIL rand_resp t=%0d: data=%h, required %h", t, resp, exp_resp);
                end
            end else if (kind == 0) begin
                model_mem[idx] = wdata;
            end
        end
    endtask

    initial begin
        bus.s_cmd_tdata   = '0;
        bus.s_cmd_tvalid  = 1'b0;
        bus.s_cmd_tlast   = 1'b0;
        bus.m_resp_tready = 1'b0;
        bus.wb_dat_i      = '0;
        bus.wb_ack_i      = 1'b0;
        bus.wb_err_i      = 1'b0;
        bus.wb_rty_i      = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_framing();
        test_backpressure();
        test_reset_mid_wb();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation time limit reached, required completion");
        $fatal(1, "bench time limit");
    end
endmodule

// File: doc/turfio_register_responder.md
# turfio_register_responder

TURFIO-side end of the crate register bridge: accepts the 32-bit command stream produced by the TURF bridge, turns each command into a single Wishbone access on the local TURFIO register space, and returns read data on a 32-bit response stream. It sits between the inbound Aurora UFC/command demux and the TURFIO Wishbone interconnect. Writes produce no response; reads produce exactly one response word.

## Interface
Parameters:
- WB_TIMEOUT, 1023: maximum cycles a Wishbone access may wait for ack/err/rty before forced termination (1..65535).

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- s_cmd_tdata  in  32  command word.
- s_cmd_tvalid  in  1  command word valid.
- s_cmd_tready  out  1  command word accepted.
- s_cmd_tlast  in  1  last word of command.
- m_resp_tdata  out  32  read response word.
- m_resp_tvalid  out  1  response valid.
- m_resp_tready  in  1  response accepted.
- wb_cyc_o, wb_stb_o  out  1 each  Wishbone cycle/strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  25  byte address, bits [1:0] always 0.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  always 4'hF.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i, wb_rty_i  in  1 each  termination.
- timeout_o  out  1  one-cycle pulse on forced termination.
- framing_error_o  out  1  one-cycle pulse on malformed command.

## Operation
- Header word: bit 31 = 1 read / 0 write; bits [30:25] ignored; bits [24:2] address; bits [1:0] ignored (wb_adr_o[1:0]=0).
- Read command: header with tlast=1. Write command: header with tlast=0, then data word with tlast=1.
- States: IDLE, DATA, WB, RESP, DRAIN.
- IDLE: s_cmd_tready=1. On beat: latch address/we. Read+tlast -> WB. Write+!tlast -> DATA. Write+tlast -> framing error, IDLE. Read+!tlast -> framing error, DRAIN.
- DATA: s_cmd_tready=1. Beat with tlast=1 -> latch wb_dat_o, WB. Beat with tlast=0 -> framing error, DRAIN (no write issued).
- DRAIN: s_cmd_tready=1; discard beats until one with tlast=1 -> IDLE.
- WB: cyc=stb=1, s_cmd_tready=0. Terminates on ack, err, rty, or timeout. Read data captured: ack -> wb_dat_i; err/rty/timeout -> 32'hFFFFFFFF. Write -> IDLE; read -> RESP.
- RESP: m_resp_tvalid=1, tdata stable until m_resp_tready; then IDLE. s_cmd_tready=0.
- Timeout counter: clears on WB entry, increments each WB cycle without termination; reaching WB_TIMEOUT terminates with timeout_o pulse. ack/err/rty in the same cycle as the count limit wins (no timeout).
- err and rty are both treated as terminal; no retry.

## Timing
- Reset (async assert): state IDLE, all outputs 0 except wb_sel_o=4'hF; m_resp_tdata=0; counter 0. Reset mid-WB drops cyc/stb immediately; pending response discarded.
- Header accepted cycle N (read): cyc/stb high from N+1. Write: data beat cycle N+1 earliest, cyc/stb from N+2.
- Termination sampled cycle M: cyc/stb low M+1; read response valid M+1.
- Minimum read turnaround (ack in first WB cycle): header at N, m_resp_tvalid at N+2.
- Next header accepted earliest cycle after return to IDLE.
- wb_adr_o/wb_we_o/wb_dat_o stable for whole WB state.
- Pulses (timeout_o, framing_error_o) registered, high exactly one cycle after the causing event.

## Test plan
- Write: header 0x0000_1234, tlast=0; data 0xDEADBEEF, tlast=1; ack after 3 cycles -> one WB write adr=0x1234, dat=0xDEADBEEF, sel=F; no m_resp beat.
- Read: header 0x8000_0010, tlast=1; ack with wb_dat_i=0xCAFEF00D -> adr=0x10, we=0; m_resp_tdata=0xCAFEF00D one beat.
- Timeout: WB_TIMEOUT=16, read with no ack -> cyc held 16 cycles, timeout_o one pulse, response 0xFFFFFFFF; err instead -> 0xFFFFFFFF, no timeout_o.
- Framing: write header with tlast=1 -> framing_error_o pulse, no WB cycle; read header tlast=0 then 2 beats ending tlast=1 -> pulse, all drained, following valid read served normally.
- Backpressure: m_resp_tready low 10 cycles -> tvalid/tdata stable, s_cmd_tready=0 throughout; next command accepted after handshake.
- Reset mid-WB: assert wb_rst_i while cyc high -> cyc/stb drop asynchronously, no response emitted, next read after reset completes correctly.
